// File: rtl/rca_adder_2op_8bit.sv
// Two-operand 8-bit ripple-carry adder with carry-in and 9-bit sum.
// Macro RCA_OUTPUT_REG_EN selects flopped S_q/Z_q/V_q; otherwise they are combinational.
module rca_adder_2op_8bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [8:0] S,
    output logic [8:0] S_q,
    output logic       Z_q,
    output logic       V_q
);

    logic [8:0] c;
    logic [7:0] s;
    logic       z;
    logic       v;

    // Eight chained full adders, carry rippling from Cin up to c[8]
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = Cin;
        for (int i = 0; i < 8; i++) begin
            s[i]     = A[i] ^ B[i] ^ c[i];
            c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
    end

    assign S = {c[8], s};
    assign z = (s == 8'h00);
    assign v = c[8] ^ c[7];

`ifdef RCA_OUTPUT_REG_EN

    // Result stage: capture sum and flags every cycle; reset clears at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_q <= 9'h000;
            Z_q <= 1'b1;
            V_q <= 1'b0;
        end else begin
            S_q <= S;
            Z_q <= z;
            V_q <= v;
        end
    end

`else

    // clk and rst_n have no job in the combinational build
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign S_q = S;
    assign Z_q = z;
    assign V_q = v;

`endif

endmodule

// File: tb/tb_rca_adder_2op_8bit.sv
// Directed-table and random bench for rca_adder_2op_8bit.
// Handles both builds of RCA_OUTPUT_REG_EN.
module tb_rca_adder_2op_8bit;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [8:0] s;
    logic [8:0] s_q;
    logic       z_q;
    logic       v_q;

    int total;
    int bad;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [8:0] s;
        logic       z;
        logic       v;
    } vec_t;

    vec_t vecs[12];

    rca_adder_2op_8bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a),
        .B     (b),
        .Cin   (cin),
        .S     (s),
        .S_q   (s_q),
        .Z_q   (z_q),
        .V_q   (v_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [8:0] act,
                       input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Registered (or combinational) outputs against expected sum and flags
    task automatic chk_out(input string name, input logic [8:0] es,
                           input logic ez, input logic ev);
        chk({name, ".S_q"}, s_q, es);
        chk({name, ".Z_q"}, {8'h0, z_q}, {8'h0, ez});
        chk({name, ".V_q"}, {8'h0, v_q}, {8'h0, ev});
    endtask

    task automatic drive(input logic [7:0] ta, input logic [7:0] tb,
                         input logic tc);
        a   = ta;
        b   = tb;
        cin = tc;
    endtask

    initial begin
        logic [8:0] exp;
        logic       ev;
        total = 0;
        bad   = 0;

        vecs[0]  = '{8'h00, 8'h00, 1'b0, 9'h000, 1'b1, 1'b0};
        vecs[1]  = '{8'h01, 8'h01, 1'b0, 9'h002, 1'b0, 1'b0};
        vecs[2]  = '{8'hFF, 8'h01, 1'b0, 9'h100, 1'b1, 1'b0};
        vecs[3]  = '{8'hFF, 8'hFF, 1'b0, 9'h1FE, 1'b0, 1'b0};
        vecs[4]  = '{8'hFF, 8'h00, 1'b0, 9'h0FF, 1'b0, 1'b0};
        vecs[5]  = '{8'd123, 8'd100, 1'b1, 9'h0E0, 1'b0, 1'b1};
        vecs[6]  = '{8'd200, 8'd55, 1'b1, 9'h100, 1'b1, 1'b0};
        vecs[7]  = '{8'h7F, 8'h01, 1'b0, 9'h080, 1'b0, 1'b1};
        vecs[8]  = '{8'h80, 8'h80, 1'b0, 9'h100, 1'b1, 1'b1};
        vecs[9]  = '{8'h00, 8'h00, 1'b1, 9'h001, 1'b0, 1'b0};
        vecs[10] = '{8'h80, 8'h7F, 1'b1, 9'h100, 1'b1, 1'b0};
        vecs[11] = '{8'h40, 8'h40, 1'b0, 9'h080, 1'b0, 1'b1};

        // Reset state, with S live during reset
        rst_n = 1'b0;
        drive(8'h12, 8'h34, 1'b0);
        #3;
        chk("rst.S", s, 9'h046);
`ifdef RCA_OUTPUT_REG_EN
        chk_out("rst", 9'h000, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk_out("rst_hold", 9'h000, 1'b1, 1'b0);
`else
        chk_out("rst", 9'h046, 1'b0, 1'b0);
`endif

        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].a, vecs[i].b, vecs[i].cin);
            #1;
            chk($sformatf("vec%0d.S", i), s, vecs[i].s);
`ifdef RCA_OUTPUT_REG_EN
            @(posedge clk);
            #1;
`endif
            chk_out($sformatf("vec%0d", i), vecs[i].s, vecs[i].z,
                    vecs[i].v);
        end

        // Mid-operation reset between clock edges
        @(negedge clk);
        drive(8'h10, 8'h20, 1'b0);
        @(posedge clk);
        #1;
        chk_out("pre_rst", 9'h030, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst.S", s, 9'h030);
`ifdef RCA_OUTPUT_REG_EN
        chk_out("mid_rst", 9'h000, 1'b1, 1'b0);
`else
        chk_out("mid_rst", 9'h030, 1'b0, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'h7F, 8'h7F, 1'b1);
        #1;
        chk("post_rst.S", s, 9'h0FF);
`ifdef RCA_OUTPUT_REG_EN
        chk_out("post_rst_hold", 9'h000, 1'b1, 1'b0);
        @(posedge clk);
        #1;
`endif
        chk_out("post_rst", 9'h0FF, 1'b0, 1'b1);

        // Random vectors against a plain arithmetic model
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            drive(8'($urandom), 8'($urandom), 1'($urandom));
            exp = {1'b0, a} + {1'b0, b} + {8'h00, cin};
            ev  = (a[7] == b[7]) && (exp[7] != a[7]);
            #1;
            chk($sformatf("rnd%0d.S", i), s, exp);
`ifdef RCA_OUTPUT_REG_EN
            @(posedge clk);
            #1;
`endif
            chk_out($sformatf("rnd%0d", i), exp, exp[7:0] == 8'h00, ev);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
